bcd_cascade_cnt: RTL and testbench

- Parametrised multi-digit BCD up/down counter with per-digit modulus (mixed radix, e.g. MM:SS), parallel load, and wrap or saturate mode.
- Successor to the fixed 2-digit up-only counter used in the stopwatch datapath. Serves both count-up stopwatch and count-down (back) timer variants.
- Digit 0 is least significant. Carry and borrow ripple combinationally across digits within one cycle.

---
 rtl/bcd_cascade_cnt_pkg.sv | 24 ++
 rtl/bcd_cascade_cnt_if.sv | 29 ++
 rtl/bcd_cascade_cnt_digit.sv | 45 ++++
 rtl/bcd_cascade_cnt.sv | 78 +++++++
 tb/tb_bcd_cascade_cnt.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_cascade_cnt_pkg.sv
// Shared definitions for the BCD cascade counter family.
//   BCD_W        - bits per BCD digit
//   SEC_MIN_MAX  - default digit maxima for an MM:SS display
//   CENTI_MAX    - default digit maxima for a 00..99 hundredths display
//   dig_max()    - pulls one digit maximum out of a packed DIG_MAX value
//   clamp_digit()- limits a load nibble to that digit's maximum
package bcd_cascade_cnt_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam logic [15:0] SEC_MIN_MAX = 16'h5959;
  localparam logic [7:0]  CENTI_MAX   = 8'h99;

  function automatic bcd_t dig_max(input logic [31:0] packed_max, input int idx);
    return packed_max[BCD_W*idx +: BCD_W];
  endfunction

  function automatic bcd_t clamp_digit(input bcd_t v, input bcd_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/bcd_cascade_cnt_if.sv
// Control/status bundle of the BCD cascade counter.
//   master: drives CLR, LOAD, DIN, EN, DIR, INC, DEC; observes Q, CA, BO, ZERO, DONE
//   slave : the counter itself (opposite directions)
interface bcd_cascade_cnt_if import bcd_cascade_cnt_pkg::*; #(
  parameter int NDIG = 4
);
  logic                  CLR;
  logic                  LOAD;
  logic [BCD_W*NDIG-1:0] DIN;
  logic                  EN;
  logic                  DIR;
  logic                  INC;
  logic                  DEC;
  logic [BCD_W*NDIG-1:0] Q;
  logic                  CA;
  logic                  BO;
  logic                  ZERO;
  logic                  DONE;

  modport master (
    output CLR, LOAD, DIN, EN, DIR, INC, DEC,
    input  Q, CA, BO, ZERO, DONE
  );

  modport slave (
    input  CLR, LOAD, DIN, EN, DIR, INC, DEC,
    output Q, CA, BO, ZERO, DONE
  );
endinterface

// File: rtl/bcd_cascade_cnt_digit.sv
// One BCD digit of the cascade counter, counting 0..MAX.
//   CLK, RST       - clock, synchronous active-high reset
//   clr, load, din - synchronous clear / parallel load (din already clamped)
//   up_in, dn_in   - step requests arriving from the lower digit (never both)
//   q              - digit value
//   up_out, dn_out - step handed to the next digit when this one rolls over
module bcd_digit import bcd_cascade_cnt_pkg::*; #(
  parameter bcd_t MAX = 4'd9
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic load,
  input  bcd_t din,
  input  logic up_in,
  input  logic dn_in,
  output bcd_t q,
  output logic up_out,
  output logic dn_out
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (load)
      q_d = din;
    else if (up_in)
      q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
    else if (dn_in)
      q_d = (q_q == '0) ? MAX : q_q - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q      = q_q;
  assign up_out = up_in & (q_q == MAX);
  assign dn_out = dn_in & (q_q == '0);

endmodule

// File: rtl/bcd_cascade_cnt.sv
// Multi-digit mixed-radix BCD up/down counter with load, clear and
// wrap/saturate behaviour at the count limits.
//   CLK, RST - clock, synchronous active-high reset
//   bus      - slave side of bcd_cascade_cnt_if:
//              CLR/LOAD/DIN/EN/DIR/INC/DEC in, Q/CA/BO/ZERO/DONE out
// Parameters: NDIG digits, DIG_MAX packed per-digit maxima, WRAP (1=wrap, 0=saturate).
module bcd_cascade_cnt import bcd_cascade_cnt_pkg::*; #(
  parameter int                  NDIG    = 4,
  parameter logic [4*NDIG-1:0]   DIG_MAX = SEC_MIN_MAX,
  parameter int                  WRAP    = 1
) (
  input  logic CLK,
  input  logic RST,
  bcd_cascade_cnt_if.slave bus
);

  localparam logic              WRAP_EN = (WRAP != 0);
  localparam logic [4*NDIG-1:0] ONE_VAL = (4*NDIG)'(1);

  bcd_t              q_dig [NDIG];
  logic [NDIG-1:0]   at_max, at_zero;
  logic [NDIG:0]     up_c, dn_c;
  logic [4*NDIG-1:0] q_all;

  logic up_req, dn_req, step_up, step_dn;
  logic all_max, all_zero;
  logic done_d, done_q;

  // Simultaneous up and down requests cancel; load/clear swallow the step.
  always_comb begin
    up_req  = (bus.EN & ~bus.DIR) | bus.INC;
    dn_req  = (bus.EN &  bus.DIR) | bus.DEC;
    step_up = up_req & ~dn_req & ~bus.CLR & ~bus.LOAD;
    step_dn = dn_req & ~up_req & ~bus.CLR & ~bus.LOAD;
    all_max  = &at_max;
    all_zero = &at_zero;
    // Saturate mode: block the step at the limit so no digit moves.
    up_c[0] = step_up & (WRAP_EN | ~all_max);
    dn_c[0] = step_dn & (WRAP_EN | ~all_zero);
    // Only a decrement from exactly 1 lands on zero.
    done_d  = step_dn & (q_all == ONE_VAL);
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam bcd_t MAX_I = dig_max(32'(DIG_MAX), i);

    bcd_digit #(.MAX(MAX_I)) u_digit (
      .CLK    (CLK),
      .RST    (RST),
      .clr    (bus.CLR),
      .load   (bus.LOAD),
      .din    (clamp_digit(bus.DIN[4*i +: 4], MAX_I)),
      .up_in  (up_c[i]),
      .dn_in  (dn_c[i]),
      .q      (q_dig[i]),
      .up_out (up_c[i+1]),
      .dn_out (dn_c[i+1])
    );

    assign at_max[i]       = (q_dig[i] == MAX_I);
    assign at_zero[i]      = (q_dig[i] == '0);
    assign q_all[4*i +: 4] = q_dig[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) done_q <= 1'b0;
    else     done_q <= done_d;
  end

  // In wrap mode the chain's carry-out is the carry; in saturate mode the
  // chain is blocked at the limit, so carry/borrow come from the limit test.
  assign bus.CA   = WRAP_EN ? up_c[NDIG] : (step_up & all_max);
  assign bus.BO   = WRAP_EN ? dn_c[NDIG] : (step_dn & all_zero);
  assign bus.Q    = q_all;
  assign bus.ZERO = all_zero;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_bcd_cascade_cnt.sv
module tb_bcd_cascade_cnt;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bcd_cascade_cnt_if #(.NDIG(4)) bw ();
  bcd_cascade_cnt_if #(.NDIG(4)) bs ();
  bcd_cascade_cnt_if #(.NDIG(2)) bc ();

  bcd_cascade_cnt #(.NDIG(4), .DIG_MAX(16'h5959), .WRAP(1)) u_w (
    .CLK(clk), .RST(rst), .bus(bw.slave));
  bcd_cascade_cnt #(.NDIG(4), .DIG_MAX(16'h5959), .WRAP(0)) u_s (
    .CLK(clk), .RST(rst), .bus(bs.slave));
  bcd_cascade_cnt #(.NDIG(2), .DIG_MAX(8'h99), .WRAP(1)) u_c (
    .CLK(clk), .RST(rst), .bus(bc.slave));

  logic [15:0] exp_up [10] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                               16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h0010};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives the two 4-digit counters (wrap and saturate) identically.
  task automatic drv(input logic clr, input logic load, input logic [15:0] din,
                     input logic en, input logic dir, input logic inc, input logic dec);
    bw.CLR = clr; bw.LOAD = load; bw.DIN = din; bw.EN = en; bw.DIR = dir; bw.INC = inc; bw.DEC = dec;
    bs.CLR = clr; bs.LOAD = load; bs.DIN = din; bs.EN = en; bs.DIR = dir; bs.INC = inc; bs.DEC = dec;
  endtask

  task automatic load_val(input logic [15:0] v);
    drv(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    bc.CLR = 1'b0; bc.LOAD = 1'b0; bc.DIN = 8'h00; bc.EN = 1'b0;
    bc.DIR = 1'b0; bc.INC = 1'b0; bc.DEC = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bw.Q !== 16'h0000) begin n_fail++; $display("FAIL reset_q_w got=%h exp=%h", bw.Q, 16'h0000); end
    n_checks++; if (bs.Q !== 16'h0000) begin n_fail++; $display("FAIL reset_q_s got=%h exp=%h", bs.Q, 16'h0000); end
    n_checks++; if (bc.Q !== 8'h00) begin n_fail++; $display("FAIL reset_q_c got=%h exp=%h", bc.Q, 8'h00); end
    n_checks++; if (bw.ZERO !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", bw.ZERO); end
    n_checks++; if (bw.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bw.DONE); end
    n_checks++; if ({bw.CA, bw.BO} !== 2'b00) begin n_fail++; $display("FAIL reset_ca_bo got=%b exp=00", {bw.CA, bw.BO}); end
  endtask

  task automatic test_count_up;
    drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (bw.Q !== exp_up[k]) begin n_fail++; $display("FAIL up_q_w step=%0d got=%h exp=%h", k, bw.Q, exp_up[k]); end
      n_checks++; if (bs.Q !== exp_up[k]) begin n_fail++; $display("FAIL up_q_s step=%0d got=%h exp=%h", k, bs.Q, exp_up[k]); end
    end
    load_val(16'h0059);
    n_checks++; if (bw.Q !== 16'h0059) begin n_fail++; $display("FAIL load_0059 got=%h exp=%h", bw.Q, 16'h0059); end
    drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bw.CA !== 1'b0) begin n_fail++; $display("FAIL ca_at_0059 got=%b exp=0", bw.CA); end
    tick();
    n_checks++; if (bw.Q !== 16'h0100) begin n_fail++; $display("FAIL carry_0059 got=%h exp=%h", bw.Q, 16'h0100); end
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap;
    load_val(16'h5958);
    drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++; if (bw.CA !== 1'b0) begin n_fail++; $display("FAIL ca_5958 got=%b exp=0", bw.CA); end
    tick();
    n_checks++; if (bw.Q !== 16'h5959) begin n_fail++; $display("FAIL wrap_q1_w got=%h exp=%h", bw.Q, 16'h5959); end
    n_checks++; if (bw.CA !== 1'b1) begin n_fail++; $display("FAIL wrap_ca_w got=%b exp=1", bw.CA); end
    n_checks++; if (bs.CA !== 1'b1) begin n_fail++; $display("FAIL wrap_ca_s got=%b exp=1", bs.CA); end
    tick();
    n_checks++; if (bw.Q !== 16'h0000) begin n_fail++; $display("FAIL wrap_q2_w got=%h exp=%h", bw.Q, 16'h0000); end
    n_checks++; if (bw.CA !== 1'b0) begin n_fail++; $display("FAIL wrap_ca2_w got=%b exp=0", bw.CA); end
    n_checks++; if (bs.Q !== 16'h5959) begin n_fail++; $display("FAIL sat_q2_s got=%h exp=%h", bs.Q, 16'h5959); end
    n_checks++; if (bs.CA !== 1'b1) begin n_fail++; $display("FAIL sat_ca2_s got=%b exp=1", bs.CA); end
    n_checks++; if (bw.DONE !== 1'b0) begin n_fail++; $display("FAIL upwrap_done got=%b exp=0", bw.DONE); end
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_count_down;
    load_val(16'h0002);
    drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++; if (bw.Q !== 16'h0001) begin n_fail++; $display("FAIL dn_q1 got=%h exp=%h", bw.Q, 16'h0001); end
    n_checks++; if (bw.DONE !== 1'b0) begin n_fail++; $display("FAIL dn_done1 got=%b exp=0", bw.DONE); end
    tick();
    n_checks++; if (bw.Q !== 16'h0000) begin n_fail++; $display("FAIL dn_q0_w got=%h exp=%h", bw.Q, 16'h0000); end
    n_checks++; if (bw.DONE !== 1'b1) begin n_fail++; $display("FAIL dn_done_w got=%b exp=1", bw.DONE); end
    n_checks++; if (bs.DONE !== 1'b1) begin n_fail++; $display("FAIL dn_done_s got=%b exp=1", bs.DONE); end
    n_checks++; if (bw.BO !== 1'b1) begin n_fail++; $display("FAIL dn_bo_w got=%b exp=1", bw.BO); end
    n_checks++; if (bs.BO !== 1'b1) begin n_fail++; $display("FAIL dn_bo_s got=%b exp=1", bs.BO); end
    tick();
    n_checks++; if (bw.Q !== 16'h5959) begin n_fail++; $display("FAIL dn_wrap_q got=%h exp=%h", bw.Q, 16'h5959); end
    n_checks++; if (bw.DONE !== 1'b0) begin n_fail++; $display("FAIL dn_wrap_done got=%b exp=0", bw.DONE); end
    n_checks++; if (bs.Q !== 16'h0000) begin n_fail++; $display("FAIL dn_sat_q got=%h exp=%h", bs.Q, 16'h0000); end
    n_checks++; if (bs.DONE !== 1'b0) begin n_fail++; $display("FAIL dn_sat_done got=%b exp=0", bs.DONE); end
    n_checks++; if (bs.BO !== 1'b1) begin n_fail++; $display("FAIL dn_sat_bo got=%b exp=1", bs.BO); end
    tick();
    n_checks++; if (bs.DONE !== 1'b0) begin n_fail++; $display("FAIL dn_sat_done2 got=%b exp=0", bs.DONE); end
    n_checks++; if (bw.Q !== 16'h5958) begin n_fail++; $display("FAIL dn_after_wrap got=%h exp=%h", bw.Q, 16'h5958); end
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_inc_dec;
    load_val(16'h1234);
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    n_checks++; if ({bw.CA, bw.BO} !== 2'b00) begin n_fail++; $display("FAIL both_ca_bo got=%b exp=00", {bw.CA, bw.BO}); end
    tick();
    n_checks++; if (bw.Q !== 16'h1234) begin n_fail++; $display("FAIL both_q got=%h exp=%h", bw.Q, 16'h1234); end
    drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (bw.Q !== 16'h1234) begin n_fail++; $display("FAIL en_dec_q got=%h exp=%h", bw.Q, 16'h1234); end
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    n_checks++; if (bw.Q !== 16'h1235) begin n_fail++; $display("FAIL inc_q got=%h exp=%h", bw.Q, 16'h1235); end
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (bw.Q !== 16'h1234) begin n_fail++; $display("FAIL dec_q got=%h exp=%h", bw.Q, 16'h1234); end
    load_val(16'h0100);
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    n_checks++; if (bw.Q !== 16'h0059) begin n_fail++; $display("FAIL borrow_0100 got=%h exp=%h", bw.Q, 16'h0059); end
    load_val(16'h9A7F);
    n_checks++; if (bw.Q !== 16'h5959) begin n_fail++; $display("FAIL clamp_9a7f got=%h exp=%h", bw.Q, 16'h5959); end
    load_val(16'h3A27);
    n_checks++; if (bw.Q !== 16'h3927) begin n_fail++; $display("FAIL clamp_3a27 got=%h exp=%h", bw.Q, 16'h3927); end
  endtask

  task automatic test_priority;
    load_val(16'h0030);
    drv(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++; if (bw.Q !== 16'h0100) begin n_fail++; $display("FAIL load_over_step got=%h exp=%h", bw.Q, 16'h0100); end
    drv(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++; if (bw.Q !== 16'h0000) begin n_fail++; $display("FAIL clr_over_load got=%h exp=%h", bw.Q, 16'h0000); end
    n_checks++; if (bw.ZERO !== 1'b1) begin n_fail++; $display("FAIL clr_zero got=%b exp=1", bw.ZERO); end
    load_val(16'h0001);
    n_checks++; if (bw.ZERO !== 1'b0) begin n_fail++; $display("FAIL nonzero got=%b exp=0", bw.ZERO); end
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    n_checks++; if (bw.Q !== 16'h0000) begin n_fail++; $display("FAIL rst_dec_q got=%h exp=%h", bw.Q, 16'h0000); end
    n_checks++; if (bw.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_dec_done got=%b exp=0", bw.DONE); end
    rst = 1'b0;
    drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_checks++; if (bw.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_dec_done2 got=%b exp=0", bw.DONE); end
  endtask

  task automatic test_two_digit;
    int ca_cnt;
    int ca_at;
    ca_cnt = 0;
    ca_at  = -1;
    bc.INC = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bc.CA === 1'b1) begin
        ca_cnt++;
        ca_at = i;
      end
      tick();
      if (i == 49) begin
        n_checks++; if (bc.Q !== 8'h50) begin n_fail++; $display("FAIL cent_mid got=%h exp=%h", bc.Q, 8'h50); end
      end
    end
    bc.INC = 1'b0;
    n_checks++; if (bc.Q !== 8'h00) begin n_fail++; $display("FAIL cent_wrap_q got=%h exp=%h", bc.Q, 8'h00); end
    n_checks++; if (ca_cnt !== 1) begin n_fail++; $display("FAIL cent_ca_count got=%0d exp=1", ca_cnt); end
    n_checks++; if (ca_at !== 99) begin n_fail++; $display("FAIL cent_ca_step got=%0d exp=99", ca_at); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_count_down();
    test_inc_dec();
    test_priority();
    test_two_digit();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
